pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised next-generation program-counter block for the pipelined core; replaces the single-cycle PC path.
- Holds the fetch PC and issues fetch addresses to instruction memory over a valid/ready handshake.
- Tracks in-flight fetches in an in-order queue so each returned instruction gets its PC tag.
- Applies taken branch, jump and register-jump redirects from the execute stage, marking wrong-path fetches stale.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_VEC, 0, PC value loaded on reset
INC, 4, sequential PC increment in bytes
DEPTH, 4, max outstanding fetches in the PC queue (power of two, >=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_addr  out  ADDR_W  current fetch PC
fetch_valid  out  1  fetch request valid
fetch_ready  in  1  instruction memory accepts the request
stall  in  1  decode backpressure; blocks new fetches
resp_valid  in  1  instruction memory returns the oldest outstanding fetch (in order)
resp_pc  out  ADDR_W  PC tag of the returning instruction (queue head)
resp_pc_valid  out  1  returning instruction is on the correct path
redirect_valid  in  1  execute-stage control-flow instruction present
leap  in  1  branch/jump condition true
branch  in  1  1 selects imm16, 0 selects imm26
reg_to_pc  in  1  jump target taken from reg_target
ex_pc  in  ADDR_W  PC of the execute-stage instruction
imm16  in  16  branch offset
imm26  in  26  jump offset
reg_target  in  ADDR_W  register jump target
flush  out  1  redirect taken this cycle; decode must squash
err  out  1  sticky: resp_valid received with empty queue

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high: PC = RESET_VEC, queue empty, all stale bits cleared, err = 0, fetch_valid = 0, flush = 0, resp_pc_valid = 0, resp_pc = 0.
- take = redirect_valid & (leap | reg_to_pc). redirect_valid with leap = 0 and reg_to_pc = 0 has no effect.
- Target selection:
  - reg_to_pc = 1: target = reg_target. This has priority over leap.
  - Otherwise: target = ex_pc + INC + sext(branch ? imm16 : imm26).
  - The immediate is sign-extended to ADDR_W and used as a byte offset with no shift.
  - Addition is modulo 2^ADDR_W; wrap-around is silent.
- fetch_valid = ~reset & ~stall & ~full & ~take. This is combinational, so no fetch issues in a redirect cycle.
- Handshake: fire = fetch_valid & fetch_ready.
  - On fire: push {fetch_addr, stale = 0} into the queue; PC <= PC + INC.
  - fetch_addr is held stable while fetch_valid = 1 and fetch_ready = 0.
- Redirect (take = 1):
  - PC <= target at the next edge.
  - Every valid queue entry gets stale = 1.
  - flush = take (combinational, same cycle).
  - Redirect overrides stall and full.
- Response:
  - On resp_valid with the queue non-empty: pop head.
  - resp_pc = head PC.
  - resp_pc_valid = resp_valid & ~head.stale & ~take.
  - When the queue is empty, resp_pc holds its last value.
- Response in a redirect cycle: the head is popped and reported invalid (it is wrong-path).
- Response with empty queue: ignored, err <= 1 (sticky until reset).
- Push and pop in the same cycle: count unchanged. Pop frees a slot only from the next cycle (full is registered-count based).
- Queue: circular buffer of DEPTH entries with wrapping pointers and a count of 0..DEPTH; full = (count == DEPTH).
- Reset asserted mid-operation discards all outstanding entries immediately; late responses then raise err.
- Latency: PC update 1 cycle after fire/take; resp_pc is combinational from the queue head.

Test Plan:
1. Reset release, fetch_ready = 1, stall = 0, RESET_VEC = 0 -> fetch_addr 0x0, 0x4, 0x8, 0xC on consecutive cycles; 5th cycle fetch_valid = 0 (full, DEPTH = 4, no responses).
2. Four fetches outstanding, then resp_valid for 4 cycles -> resp_pc 0x0, 0x4, 0x8, 0xC with resp_pc_valid = 1; queue empty afterwards, fetch resumes at 0x10.
3. Branch: ex_pc = 0x100, branch = 1, leap = 1, imm16 = 0xFFF8 -> flush = 1 that cycle, next fetch_addr = 0xFC. Outstanding entries return with resp_pc_valid = 0; the first post-redirect fetch returns valid.
4. Register jump with stall = 1: reg_to_pc = 1, leap = 0, reg_target = 0x2000 -> PC becomes 0x2000 despite stall. fetch_valid stays 0 until stall drops, then issues 0x2000.
5. Jump imm26 = 0x3FFFFFC (-4) from ex_pc = 0x0 -> target 0x0; redirect_valid = 1 with leap = 0, reg_to_pc = 0 -> no PC change, flush = 0.
6. Edge cases:
   - resp_valid with empty queue -> err = 1 and stays 1.
   - fetch_ready = 0 for 3 cycles -> fetch_addr stable.
   - reset pulse mid-stream -> fetch_addr = RESET_VEC, queue empty, asynchronously.

Source files
------------

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program-counter and fetch-issue block for the pipelined core.
//            Holds the fetch PC, issues fetch addresses over a valid/ready
//            handshake, tags returning instructions with their PC through an
//            in-order queue, and applies execute-stage redirects. A redirect
//            marks every outstanding (wrong-path) fetch stale.
// Ports    : clk, reset                      - clock, async active-high reset
//            fetch_addr/valid/ready          - fetch request handshake
//            stall                           - decode backpressure
//            resp_valid, resp_pc, resp_pc_valid - in-order response tagging
//            redirect_valid, leap, branch, reg_to_pc, ex_pc,
//            imm16, imm26, reg_target        - execute-stage redirect inputs
//            flush                           - redirect taken this cycle
//            err                             - sticky response-underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int unsigned           ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]     RESET_VEC = '0,
    parameter int unsigned           INC       = 4,
    parameter int unsigned           DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    input  logic              stall,
    input  logic              resp_valid,
    output logic [ADDR_W-1:0] resp_pc,
    output logic              resp_pc_valid,
    input  logic              redirect_valid,
    input  logic              leap,
    input  logic              branch,
    input  logic              reg_to_pc,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              flush,
    output logic              err
);

    localparam int unsigned        c_PTR_W = $clog2(DEPTH);
    localparam int unsigned        c_CNT_W = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0]  c_INC   = ADDR_W'(INC);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // State
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_q_pc [DEPTH];
    logic [DEPTH-1:0]   r_q_stale;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_last_pc;
    logic               r_err;

    // Combinational
    logic               w_take;
    logic               w_full;
    logic               w_empty;
    logic               w_fire;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_imm_sext;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_head_pc;
    logic               w_head_stale;

    always_comb begin
        w_take       = redirect_valid & (leap | reg_to_pc);
        // Full is based on the registered count, so a pop frees its slot
        // only from the following cycle.
        w_full       = (r_count == c_DEPTH);
        w_empty      = (r_count == '0);
        w_head_pc    = r_q_pc[r_rd_ptr];
        w_head_stale = r_q_stale[r_rd_ptr];

        // Immediate is a byte offset: sign-extended, not shifted.
        w_imm_sext = branch ? {{(ADDR_W-16){imm16[15]}}, imm16}
                            : {{(ADDR_W-26){imm26[25]}}, imm26};
        w_target   = reg_to_pc ? reg_target : (ex_pc + c_INC + w_imm_sext);

        fetch_valid = ~reset & ~stall & ~w_full & ~w_take;
        w_fire      = fetch_valid & fetch_ready;
        w_pop       = resp_valid & ~w_empty;
    end

    assign fetch_addr    = r_pc;
    assign flush         = w_take & ~reset;
    // With nothing outstanding the tag holds the last popped PC.
    assign resp_pc       = w_empty ? r_last_pc : w_head_pc;
    // A response in a redirect cycle belongs to the wrong path as well.
    assign resp_pc_valid = resp_valid & ~w_empty & ~w_head_stale & ~w_take;
    assign err           = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_VEC;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_last_pc <= '0;
            r_err     <= 1'b0;
            r_q_stale <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_pc[i] <= '0;
            end
        end else begin
            if (w_take) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + c_INC;
            end

            // Marking every slot is safe: a push always clears its own bit,
            // and no push can happen in a redirect cycle.
            if (w_take) begin
                r_q_stale <= '1;
            end

            if (w_fire) begin
                r_q_pc[r_wr_ptr]    <= r_pc;
                r_q_stale[r_wr_ptr] <= 1'b0;
                r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
            end

            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
                r_last_pc <= w_head_pc;
            end

            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (resp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit. A reference model keeps
//            the PC and the list of in-flight fetches; responses it predicts
//            go into a scoreboard queue that a separate monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        resp_pc_valid;
    logic        redirect_valid;
    logic        leap;
    logic        branch;
    logic        reg_to_pc;
    logic [31:0] ex_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] reg_target;
    logic        flush;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_unit #(
        .ADDR_W    (32),
        .RESET_VEC (32'h0),
        .INC       (4),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_pc        (resp_pc),
        .resp_pc_valid  (resp_pc_valid),
        .redirect_valid (redirect_valid),
        .leap           (leap),
        .branch         (branch),
        .reg_to_pc      (reg_to_pc),
        .ex_pc          (ex_pc),
        .imm16          (imm16),
        .imm26          (imm26),
        .reg_target     (reg_target),
        .flush          (flush),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: PC value plus an ordered list of in-flight fetches.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        bit          valid;
    } exp_t;

    ent_t        m_q[$];
    exp_t        exp_q[$];
    logic [31:0] m_pc  = 32'h0;
    bit          m_err = 1'b0;
    bit          m_take;
    bit          m_fv;
    ent_t        m_e;
    logic signed [31:0] m_off;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_fetch_valid", fetch_valid, 0);
            chk("rst_fetch_addr", fetch_addr, 32'h0);
            chk("rst_flush", flush, 0);
            chk("rst_err", err, 0);
            chk("rst_resp_pc", resp_pc, 32'h0);
            chk("rst_resp_pc_valid", resp_pc_valid, 0);
            m_q.delete();
            exp_q.delete();
            m_pc  = 32'h0;
            m_err = 1'b0;
        end else begin
            m_take = redirect_valid && (leap || reg_to_pc);
            m_fv   = !stall && (m_q.size() < DEPTH) && !m_take;
            chk("fetch_valid", fetch_valid, m_fv);
            chk("fetch_addr", fetch_addr, m_pc);
            chk("flush", flush, m_take);
            chk("err", err, m_err);

            if (resp_valid) begin
                if (m_q.size() > 0) begin
                    m_e = m_q.pop_front();
                    exp_q.push_back('{pc: m_e.pc, valid: !m_e.stale && !m_take});
                end else begin
                    m_err = 1'b1;
                end
            end

            if (m_take) begin
                foreach (m_q[i]) m_q[i].stale = 1'b1;
                if (reg_to_pc) begin
                    m_pc = reg_target;
                end else begin
                    m_off = branch ? 32'($signed(imm16)) : 32'($signed(imm26));
                    m_pc  = ex_pc + 32'd4 + m_off;
                end
            end else if (m_fv && fetch_ready) begin
                m_q.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Monitor: drains the scoreboard whenever a response is presented.
    exp_t mon_e;
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (resp_valid && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("resp_pc", resp_pc, mon_e.pc);
                chk("resp_pc_valid", resp_pc_valid, mon_e.valid);
            end else begin
                chk("resp_pc_valid_idle", resp_pc_valid, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redirect();
        redirect_valid = 1'b0;
        leap           = 1'b0;
        branch         = 1'b0;
        reg_to_pc      = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        fetch_ready = 1'b0;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        ex_pc       = '0;
        imm16       = '0;
        imm26       = '0;
        reg_target  = '0;
        clr_redirect();
        repeat (2) step();
        reset = 1'b0;

        // 1: four sequential fetches fill the queue
        fetch_ready = 1'b1;
        #1 chk("t1_first_addr", fetch_addr, 32'h0);
        repeat (4) step();
        #1;
        chk("t1_full_no_fetch", fetch_valid, 0);
        chk("t1_pc_after_fill", fetch_addr, 32'h10);
        step();

        // 2: drain four responses without fetching
        fetch_ready = 1'b0;
        resp_valid  = 1'b1;
        repeat (4) step();
        resp_valid  = 1'b0;
        fetch_ready = 1'b1;
        #1 chk("t2_resume_valid", fetch_valid, 1);
        chk("t2_resume_addr", fetch_addr, 32'h10);

        // 3: branch with two fetches outstanding
        repeat (2) step();
        redirect_valid = 1'b1; leap = 1'b1; branch = 1'b1;
        ex_pc = 32'h100; imm16 = 16'hFFF8;
        #1 chk("t3_flush", flush, 1);
        chk("t3_no_fetch", fetch_valid, 0);
        step();
        clr_redirect();
        #1 chk("t3_target", fetch_addr, 32'hFC);
        step();
        fetch_ready = 1'b0;
        resp_valid  = 1'b1;
        repeat (3) step();
        resp_valid  = 1'b0;

        // 4: register jump while stalled
        stall = 1'b1;
        redirect_valid = 1'b1; reg_to_pc = 1'b1; reg_target = 32'h2000;
        #1 chk("t4_flush", flush, 1);
        step();
        clr_redirect();
        #1 chk("t4_pc", fetch_addr, 32'h2000);
        chk("t4_stalled", fetch_valid, 0);
        repeat (2) step();
        stall = 1'b0;
        fetch_ready = 1'b1;
        #1 chk("t4_issue", fetch_valid, 1);
        step();

        // 5: negative imm26 jump, then a not-taken redirect
        fetch_ready = 1'b0;
        redirect_valid = 1'b1; leap = 1'b1; branch = 1'b0;
        ex_pc = 32'h0; imm26 = 26'h3FFFFFC;
        step();
        clr_redirect();
        #1 chk("t5_target", fetch_addr, 32'h0);
        redirect_valid = 1'b1; ex_pc = 32'h500; imm16 = 16'h0040;
        #1 chk("t5_no_flush", flush, 0);
        step();
        clr_redirect();
        #1 chk("t5_pc_kept", fetch_addr, 32'h0);

        // 6: drain past empty -> sticky err; held fetch; async reset pulse
        resp_valid = 1'b1;
        repeat (6) step();
        resp_valid = 1'b0;
        #1 chk("t6_err", err, 1);
        repeat (3) step();
        chk("t6_err_sticky", err, 1);
        fetch_ready = 1'b1;
        repeat (2) step();
        fetch_ready = 1'b0;
        repeat (3) step();
        #1 reset = 1'b1;
        #1 chk("t6_async_addr", fetch_addr, 32'h0);
        chk("t6_async_err", err, 0);
        chk("t6_async_fv", fetch_valid, 0);
        step();
        reset = 1'b0;
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        #1 chk("t6_late_resp_err", err, 1);

        // Randomised phase
        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            resp_valid  = ($urandom_range(0, 1) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            leap        = $urandom_range(0, 1);
            branch      = $urandom_range(0, 1);
            reg_to_pc   = ($urandom_range(0, 3) == 0);
            ex_pc       = $urandom & 32'hFFFF_FFFC;
            imm16       = 16'($urandom);
            imm26       = 26'($urandom);
            reg_target  = $urandom;
            reset       = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        resp_valid = 1'b0;
        clr_redirect();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
